// File: rtl/frame_pkg.sv
// Shared definitions for the static frame store.
//   FRAME_W/FRAME_H : default frame geometry (VGA width, 480 lines)
//   PIXEL_W         : grayscale pixel width
//   ADDR_W          : read/write address width, y*FRAME_W+x
//   pixel_t/addr_t  : pixel and address types
//   fs_state_t      : capture controller states
package frame_pkg;

   localparam int FRAME_W      = 640;
   localparam int FRAME_H      = 480;
   localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
   localparam int PIXEL_W      = 4;
   localparam int ADDR_W       = 19;

   typedef logic [PIXEL_W-1:0] pixel_t;
   typedef logic [ADDR_W-1:0]  addr_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      CAPTURE  = 2'd2,
      SWAP     = 2'd3
   } fs_state_t;

endpackage

// File: rtl/frame_bank.sv
// One frame bank: simple dual-port RAM, one write port, one registered read port.
//   clk     : clock
//   wr_en   : write strobe
//   wr_idx  : write index
//   wr_data : write pixel
//   rd_idx  : read index, sampled every cycle
//   rd_data : pixel at rd_idx, one cycle later
// No reset on the storage or the read register so the array maps onto block RAM.
module frame_bank
   import frame_pkg::*;
#(
   parameter int DEPTH = FRAME_PIXELS,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [PIXEL_W-1:0] wr_data,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [PIXEL_W-1:0] rd_data
);

   pixel_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
      rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/static_frame_store.sv
// Ping-pong frame store between the camera pixel stream and the correlator.
// One bank is filled from the camera while the other, the last completed frame,
// serves correlator reads. Banks swap once per completed frame.
//   clk         : clock, posedge
//   rst         : asynchronous reset, active-high
//   capture_en  : capture enable; low forces the controller idle
//   cam_pixel   : camera pixel, raster order
//   cam_valid   : cam_pixel valid this cycle
//   cam_sof     : start of frame, qualifies the first pixel
//   rd_addr     : correlator read address, y*FRAME_W+x
//   rd_pixel    : pixel at rd_addr, 1-cycle latency, 0 outside the frame
//   frame_rdy   : completed frame readable; low for the single swap cycle
//   frame_count : completed frames, wraps 255->0
//   sync_err    : sticky, start of frame seen mid-frame
//
// state    | meaning
// IDLE     | capture disabled, nothing written
// WAIT_SOF | waiting for a valid pixel flagged start-of-frame
// CAPTURE  | writing pixels into the write bank in raster order
// SWAP     | one cycle: exchange read and write banks, count the frame
module static_frame_store #(
   parameter int FRAME_W = frame_pkg::FRAME_W,
   parameter int FRAME_H = frame_pkg::FRAME_H
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         capture_en,
   input  logic [frame_pkg::PIXEL_W-1:0] cam_pixel,
   input  logic                         cam_valid,
   input  logic                         cam_sof,
   input  logic [frame_pkg::ADDR_W-1:0]  rd_addr,
   output logic [frame_pkg::PIXEL_W-1:0] rd_pixel,
   output logic                         frame_rdy,
   output logic [7:0]                   frame_count,
   output logic                         sync_err
);

   import frame_pkg::*;

   localparam int    N_PIX     = FRAME_W * FRAME_H;
   localparam int    IDX_W     = $clog2(N_PIX);
   localparam addr_t LAST_ADDR = addr_t'(N_PIX - 1);
   localparam addr_t END_ADDR  = addr_t'(N_PIX);

   fs_state_t state;
   logic      wr_bank;
   logic      rd_bank;
   addr_t     wr_addr;

   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;

   // A start-of-frame pixel always lands at address 0, whether it opens a
   // frame or restarts one that lost sync.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = wr_addr[IDX_W-1:0];
      if (capture_en && cam_valid) begin
         case (state)
            WAIT_SOF: begin
               if (cam_sof) begin
                  wr_en  = 1'b1;
                  wr_idx = '0;
               end
            end
            CAPTURE: begin
               wr_en = 1'b1;
               if (cam_sof) begin
                  wr_idx = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b1;
         wr_addr     <= '0;
         frame_rdy   <= 1'b0;
         frame_count <= '0;
         sync_err    <= 1'b0;
      end else if (!capture_en) begin
         // Partial frame is abandoned; the write bank is simply overwritten
         // by the next capture.
         state     <= IDLE;
         wr_addr   <= '0;
         frame_rdy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= WAIT_SOF;
            end
            WAIT_SOF: begin
               if (cam_valid && cam_sof) begin
                  wr_addr <= addr_t'(1);
                  state   <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (cam_valid) begin
                  if (cam_sof) begin
                     sync_err <= 1'b1;
                     wr_addr  <= addr_t'(1);
                  end else begin
                     wr_addr <= wr_addr + addr_t'(1);
                     if (wr_addr == LAST_ADDR) begin
                        state     <= SWAP;
                        frame_rdy <= 1'b0;
                     end
                  end
               end
            end
            SWAP: begin
               rd_bank     <= wr_bank;
               wr_bank     <= ~wr_bank;
               frame_count <= frame_count + 8'd1;
               wr_addr     <= '0;
               frame_rdy   <= 1'b1;
               state       <= WAIT_SOF;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Bank select and range check travel alongside the RAM read so the mux
   // uses the rd_bank of the cycle the address was sampled. Clearing rd_hit_q
   // on reset forces rd_pixel to 0 without resetting the RAM outputs.
   logic   rd_sel_q;
   logic   rd_hit_q;
   pixel_t bank0_q;
   pixel_t bank1_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_sel_q <= 1'b0;
         rd_hit_q <= 1'b0;
      end else begin
         rd_sel_q <= rd_bank;
         rd_hit_q <= (rd_addr < END_ADDR);
      end
   end

   frame_bank #(
      .DEPTH (N_PIX),
      .IDX_W (IDX_W)
   ) u_bank0 (
      .clk     (clk),
      .wr_en   (wr_en & ~wr_bank),
      .wr_idx  (wr_idx),
      .wr_data (cam_pixel),
      .rd_idx  (rd_addr[IDX_W-1:0]),
      .rd_data (bank0_q)
   );

   frame_bank #(
      .DEPTH (N_PIX),
      .IDX_W (IDX_W)
   ) u_bank1 (
      .clk     (clk),
      .wr_en   (wr_en & wr_bank),
      .wr_idx  (wr_idx),
      .wr_data (cam_pixel),
      .rd_idx  (rd_addr[IDX_W-1:0]),
      .rd_data (bank1_q)
   );

   assign rd_pixel = rd_hit_q ? (rd_sel_q ? bank1_q : bank0_q) : '0;

endmodule

// File: tb/tb_static_frame_store.sv
module tb_static_frame_store;

   localparam int FW = 8;
   localparam int FH = 4;
   localparam int NP = FW * FH;

   localparam int M_IDLE = 0;
   localparam int M_WAIT = 1;
   localparam int M_CAP  = 2;
   localparam int M_SWAP = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        capture_en = 1'b0;
   logic [3:0]  cam_pixel = '0;
   logic        cam_valid = 1'b0;
   logic        cam_sof = 1'b0;
   logic [18:0] rd_addr = '0;
   logic [3:0]  rd_pixel;
   logic        frame_rdy;
   logic [7:0]  frame_count;
   logic        sync_err;

   always #5 clk = ~clk;

   static_frame_store #(
      .FRAME_W (FW),
      .FRAME_H (FH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .capture_en  (capture_en),
      .cam_pixel   (cam_pixel),
      .cam_valid   (cam_valid),
      .cam_sof     (cam_sof),
      .rd_addr     (rd_addr),
      .rd_pixel    (rd_pixel),
      .frame_rdy   (frame_rdy),
      .frame_count (frame_count),
      .sync_err    (sync_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: the readable frame is a plain array that is replaced wholesale
   // by the capture buffer whenever a frame completes.
   int m_phase;
   int m_pos;
   int m_cnt;
   bit m_rdy;
   bit m_err;
   bit m_have;
   int m_disp [NP];
   int m_wbuf [NP];

   task automatic model_reset();
      m_phase = M_IDLE;
      m_pos   = 0;
      m_cnt   = 0;
      m_rdy   = 1'b0;
      m_err   = 1'b0;
      m_have  = 1'b0;
   endtask

   task automatic model_edge(input bit cap, input bit v, input bit s, input int pix);
      if (!cap) begin
         m_phase = M_IDLE;
         m_pos   = 0;
         m_rdy   = 1'b0;
      end else begin
         case (m_phase)
            M_IDLE: m_phase = M_WAIT;
            M_WAIT: begin
               if (v && s) begin
                  m_wbuf[0] = pix;
                  m_pos     = 1;
                  m_phase   = M_CAP;
               end
            end
            M_CAP: begin
               if (v) begin
                  if (s) begin
                     m_err     = 1'b1;
                     m_wbuf[0] = pix;
                     m_pos     = 1;
                  end else begin
                     m_wbuf[m_pos] = pix;
                     if (m_pos == NP - 1) begin
                        m_phase = M_SWAP;
                        m_rdy   = 1'b0;
                     end else begin
                        m_pos++;
                     end
                  end
               end
            end
            default: begin
               m_disp  = m_wbuf;
               m_have  = 1'b1;
               m_cnt   = (m_cnt + 1) % 256;
               m_pos   = 0;
               m_rdy   = 1'b1;
               m_phase = M_WAIT;
            end
         endcase
      end
   endtask

   task automatic step(input bit cap, input bit v, input bit s, input int pix, input int addr);
      int exp_rd;
      bit rd_known;
      @(negedge clk);
      capture_en = cap;
      cam_valid  = v;
      cam_sof    = s;
      cam_pixel  = pix[3:0];
      rd_addr    = addr[18:0];
      @(posedge clk);
      if (rst) begin
         model_reset();
         rd_known = 1'b1;
         exp_rd   = 0;
      end else begin
         if (addr >= NP) begin
            rd_known = 1'b1;
            exp_rd   = 0;
         end else begin
            rd_known = m_have;
            exp_rd   = m_disp[addr];
         end
         model_edge(cap, v, s, pix & 15);
      end
      #1;
      check_val("frame_rdy", int'(frame_rdy), int'(m_rdy));
      check_val("frame_count", int'(frame_count), m_cnt);
      check_val("sync_err", int'(sync_err), int'(m_err));
      if (rd_known) begin
         check_val($sformatf("rd_pixel@%0d", addr), int'(rd_pixel), exp_rd);
      end
   endtask

   function automatic int ra();
      return int'($urandom_range(0, 39));
   endfunction

   function automatic int pix_of(input int kind, input int i);
      if (kind == 0) return i % 16;
      if (kind == 1) return 15 - (i % 16);
      return int'($urandom_range(0, 15));
   endfunction

   task automatic stream(input int kind, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               step(1'b1, 1'b0, 1'b0, int'($urandom_range(0, 15)), ra());
            end
         end
         step(1'b1, 1'b1, (i == 0), pix_of(kind, i), ra());
      end
   endtask

   task automatic send_frame(input int kind, input bit gaps);
      stream(kind, NP, gaps);
      repeat (3) step(1'b1, 1'b0, 1'b0, 0, ra());
   endtask

   task automatic sweep();
      for (int a = 0; a < 40; a++) begin
         step(1'b1, 1'b0, 1'b0, 0, a);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_rd_pixel"}, int'(rd_pixel), 0);
      check_val({tag, "_frame_rdy"}, int'(frame_rdy), 0);
      check_val({tag, "_frame_count"}, int'(frame_count), 0);
      check_val({tag, "_sync_err"}, int'(sync_err), 0);
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #1 check_all_zero("reset");
      repeat (2) step(1'b0, 1'b0, 1'b0, 0, 0);
      rst = 1'b0;

      // 1: first frame, ascending pattern
      step(1'b1, 1'b0, 1'b0, 0, ra());
      send_frame(0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 0, 5);

      // 2: second frame, descending pattern
      send_frame(1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 0, 5);

      // 3: restart at pixel 12; reads during the partial frame see frame 2
      stream(2, 12, 1'b0);
      send_frame(2, 1'b0);
      step(1'b1, 1'b0, 1'b0, 0, 0);

      // 4: capture dropped at pixel 20, then resumed
      stream(2, 20, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 0, ra());
      step(1'b1, 1'b0, 1'b0, 0, ra());
      send_frame(2, 1'b0);

      // 5: strays while waiting for sof, gaps inside the frame
      repeat (3) step(1'b1, 1'b1, 1'b0, int'($urandom_range(0, 15)), ra());
      send_frame(2, 1'b1);
      sweep();

      // 6: out-of-range read, then async reset mid-capture
      step(1'b1, 1'b0, 1'b0, 0, 40);
      stream(2, 15, 1'b0);
      #1 rst = 1'b1;
      #1 check_all_zero("async_rst");
      model_reset();
      repeat (2) step(1'b1, 1'b1, 1'b0, 3, ra());
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b0, 0, ra());
      send_frame(2, 1'b1);
      sweep();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
